// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer encodings, bus widths and the
// bundle of master-side address/control signals.
package ahbl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    htrans_e           htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
  } ahbl_master_t;

  // NONSEQ and SEQ both carry a real transfer request.
  function automatic logic is_req(input htrans_e t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_arb_wait_cnt.sv
// Per-master stall counter: counts cycles spent requesting without the grant,
// saturates at 16 bits, and raises a sticky starvation flag at WAIT_LIMIT.
module ahbl_arb_wait_cnt #(
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic granted_i,
  output logic starve_o
);

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  logic [15:0] cnt_q, cnt_d;
  logic        starve_q, starve_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (granted_i) begin
      cnt_d = '0;
    end else if (req_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    starve_d = starve_q | (cnt_d >= LIMIT);
  end

  assign starve_o = starve_q;

endmodule

// File: rtl/ahbl_arb2.sv
// Two-master AHB-Lite arbiter/multiplexer. Ownership changes only when the
// granted master is IDLE, unlocked and the bus is ready; losers see HREADY low.
module ahbl_arb2
  import ahbl_pkg::*;
#(
  parameter logic        DEFAULT_MASTER = 1'b0,
  parameter int unsigned WAIT_LIMIT     = 64
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic [3:0]        M0_HPROT,
  input  logic              M0_HMASTLOCK,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  output logic [DATA_W-1:0] M0_HRDATA,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic [3:0]        M1_HPROT,
  input  logic              M1_HMASTLOCK,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADYIN,
  input  logic              HRESP,
  output logic              GRANT,
  output logic [1:0]        STARVE
);

  ahbl_master_t m0, m1, bus_m;
  logic grant_q, grant_d;
  logic dp_owner_q, dp_owner_d;
  logic dp_valid_q, dp_valid_d;
  logic req0, req1, req_other, boundary;

  assign m0 = '{haddr: M0_HADDR, htrans: htrans_e'(M0_HTRANS), hwrite: M0_HWRITE,
                hsize: M0_HSIZE, hburst: M0_HBURST, hprot: M0_HPROT,
                hmastlock: M0_HMASTLOCK};
  assign m1 = '{haddr: M1_HADDR, htrans: htrans_e'(M1_HTRANS), hwrite: M1_HWRITE,
                hsize: M1_HSIZE, hburst: M1_HBURST, hprot: M1_HPROT,
                hmastlock: M1_HMASTLOCK};

  assign req0      = M0_HTRANS[1];
  assign req1      = M1_HTRANS[1];
  assign bus_m     = grant_q ? m1 : m0;
  assign req_other = grant_q ? req0 : req1;
  // The owner's final data phase completes on this same edge, so nothing is left in flight.
  assign boundary  = HREADYIN && (bus_m.htrans == HTRANS_IDLE) && !bus_m.hmastlock && req_other;

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      grant_q    <= DEFAULT_MASTER;
      dp_owner_q <= DEFAULT_MASTER;
      dp_valid_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      dp_owner_q <= dp_owner_d;
      dp_valid_q <= dp_valid_d;
    end
  end

  always_comb begin
    grant_d    = grant_q;
    dp_owner_d = dp_owner_q;
    dp_valid_d = dp_valid_q;
    if (boundary) begin
      grant_d = ~grant_q;
    end
    if (HREADYIN) begin
      dp_owner_d = grant_q;
      dp_valid_d = is_req(bus_m.htrans);
    end
  end

  always_comb begin
    HADDR     = bus_m.haddr;
    HTRANS    = bus_m.htrans;
    HWRITE    = bus_m.hwrite;
    HSIZE     = bus_m.hsize;
    HBURST    = bus_m.hburst;
    HPROT     = bus_m.hprot;
    HMASTLOCK = bus_m.hmastlock;
    HWDATA    = dp_owner_q ? M1_HWDATA : M0_HWDATA;
    M0_HREADY = grant_q ? ~req0 : HREADYIN;
    M1_HREADY = grant_q ? HREADYIN : ~req1;
    M0_HRESP  = dp_valid_q && !dp_owner_q && HRESP;
    M1_HRESP  = dp_valid_q && dp_owner_q && HRESP;
    M0_HRDATA = HRDATA;
    M1_HRDATA = HRDATA;
    GRANT     = grant_q;
  end

  ahbl_arb_wait_cnt #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait0 (
    .clk_i     (HCLK),
    .rst_ni    (HRESETN),
    .req_i     (req0),
    .granted_i (~grant_q),
    .starve_o  (STARVE[0])
  );

  ahbl_arb_wait_cnt #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait1 (
    .clk_i     (HCLK),
    .rst_ni    (HRESETN),
    .req_i     (req1),
    .granted_i (grant_q),
    .starve_o  (STARVE[1])
  );

endmodule
